// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor (ADD/ADC/SUB/SBB) with cout/ovf/zero/neg flags.
// Latency WIDTH/4 cycles (one 4-bit lookahead group per stage); one op per cycle when not stalled.
// Backpressure: a held result freezes every stage together; in_ready is that same advance enable.
module cla_pipe_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    // One pipeline stage per 4-bit group; WIDTH must be a multiple of 4, at least 4.
    localparam int N = WIDTH / 4;

    // Full 4-bit lookahead, no ripple inside the group: returns {group carry out, sum[3:0]}.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] w_g;
        logic [3:0] w_p;
        logic [3:0] w_c;
        logic       w_co;
        w_g    = x & y;
        w_p    = x ^ y;
        w_c[0] = ci;
        w_c[1] = w_g[0] | (w_p[0] & ci);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & ci);
        w_co   = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
               | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);
        cla4   = {w_co, w_p ^ w_c};
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_b_cond;
    logic             w_c0;

    logic             r_out_vld;
    logic [WIDTH-1:0] r_res;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_neg;

    // The whole pipe moves only when the output slot is empty or being drained.
    assign w_adv     = !r_out_vld || out_ready;
    assign in_ready  = w_adv;

    assign out_valid = r_out_vld;
    assign r         = r_res;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;

    // Operand conditioning: subtract forms add ~B; the initial carry encodes cin/borrow.
    always_comb begin
        w_b_cond = op[1] ? ~b : b;
        case (op)
            2'b00:   w_c0 = 1'b0;
            2'b01:   w_c0 = cin;
            2'b10:   w_c0 = 1'b1;
            default: w_c0 = ~cin;
        endcase
    end

    genvar k;
    generate
        for (k = 0; k < N; k++) begin : g_stg
            // B bits still to be consumed at this stage's input (current group in the low 4).
            localparam int RB = WIDTH - 4 * k;

            logic             w_vld;
            logic             w_c;
            // Low 4k bits hold finished sum bits, the rest still hold operand A.
            logic [WIDTH-1:0] w_as;
            logic [RB-1:0]    w_b;
            logic [4:0]       w_grp;
            logic [WIDTH-1:0] w_as_nxt;

            if (k == 0) begin : g_src
                assign w_vld = in_valid;
                assign w_c   = w_c0;
                assign w_as  = a;
                assign w_b   = w_b_cond;
            end else begin : g_src
                assign w_vld = g_stg[k-1].g_reg.r_vld;
                assign w_c   = g_stg[k-1].g_reg.r_c;
                assign w_as  = g_stg[k-1].g_reg.r_as;
                assign w_b   = g_stg[k-1].g_reg.r_b;
            end

            assign w_grp = cla4(w_as[4*k +: 4], w_b[3:0], w_c);

            // Splice this group's sum into the A/sum skew vector.
            always_comb begin
                w_as_nxt          = w_as;
                w_as_nxt[4*k +: 4] = w_grp[3:0];
            end

            if (k < N - 1) begin : g_reg
                logic             r_vld;
                logic             r_c;
                logic [WIDTH-1:0] r_as;
                logic [RB-5:0]    r_b;

                // Stage register: group carry, skewed operands and partial result move together.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_vld <= 1'b0;
                        r_c   <= 1'b0;
                        r_as  <= '0;
                        r_b   <= '0;
                    end else if (w_adv) begin
                        r_vld <= w_vld;
                        r_c   <= w_grp[4];
                        r_as  <= w_as_nxt;
                        r_b   <= w_b[RB-1:4];
                    end
                end
            end else begin : g_out
                // Carry into the MSB recovered from the MSB sum: s = a ^ b ^ c.
                logic w_c_msb;
                assign w_c_msb = w_as_nxt[WIDTH-1] ^ w_as[WIDTH-1] ^ w_b[3];

                // Output register: result and all flags update together, only for real ops.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_out_vld <= 1'b0;
                        r_res     <= '0;
                        r_cout    <= 1'b0;
                        r_ovf     <= 1'b0;
                        r_zero    <= 1'b0;
                        r_neg     <= 1'b0;
                    end else if (w_adv) begin
                        r_out_vld <= w_vld;
                        if (w_vld) begin
                            r_res  <= w_as_nxt;
                            r_cout <= w_grp[4];
                            r_ovf  <= w_grp[4] ^ w_c_msb;
                            r_zero <= (w_as_nxt == '0);
                            r_neg  <= w_as_nxt[WIDTH-1];
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed bench for cla_pipe_adder at WIDTH=16: arithmetic/flag vectors, latency,
// stall behaviour with in-order delivery, and asynchronous reset with ops in flight.
module tb_cla_pipe_adder;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] r;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    int n_cmp = 0;
    int n_bad = 0;

    int sent, got, stalls, cyc, quiet;
    logic             prev_stall;
    logic [WIDTH-1:0] prev_r;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    // One isolated op: accept, scramble inputs, measure latency, check result and flags.
    task automatic do_op(input string tag, input logic [1:0] o, input logic [15:0] ia,
                         input logic [15:0] ib, input logic ic, input logic [15:0] er,
                         input logic ec, input logic eo, input logic ez, input logic en);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = ia; b = ib; cin = ic;
        #1;
        chk({tag, ".in_ready"}, in_ready, 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0; op = ~o; a = ~ia; b = ~ib; cin = ~ic;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, ".latency"}, lat, 4);
        chk({tag, ".r"}, r, er);
        chk({tag, ".cout"}, cout, ec);
        chk({tag, ".ovf"}, ovf, eo);
        chk({tag, ".zero"}, zero, ez);
        chk({tag, ".neg"}, neg, en);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; op = 2'b00;
        #12;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.r", r, 0);
        chk("reset.flags", {cout, ovf, zero, neg}, 0);
        chk("reset.in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        //     tag         op     a        b        cin   r        c  o  z  n
        do_op("add_basic", 2'b00, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 0, 0, 0, 0);
        do_op("add_wrap",  2'b00, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1, 0, 1, 0);
        do_op("add_ovf",   2'b00, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 0, 1, 0, 1);
        do_op("add_cin_x", 2'b00, 16'h0001, 16'h0002, 1'b1, 16'h0003, 0, 0, 0, 0);
        do_op("sub_neg",   2'b10, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 0, 0, 0, 1);
        do_op("sub_ovf",   2'b10, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1, 1, 0, 0);
        do_op("sub_cin_x", 2'b10, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1, 0, 0, 0);
        do_op("adc_chain", 2'b01, 16'h0001, 16'h0002, 1'b1, 16'h0004, 0, 0, 0, 0);
        do_op("adc_c0",    2'b01, 16'h1234, 16'h0F0F, 1'b0, 16'h2143, 0, 0, 0, 0);
        do_op("sbb_chain", 2'b11, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1, 0, 0, 0);
        do_op("sbb_nb",    2'b11, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1, 0, 0, 0);

        // Back-to-back ADD i+i with out_ready low for cycles 5..7.
        sent = 0; got = 0; stalls = 0; cyc = 0; prev_stall = 1'b0; prev_r = '0;
        while (got < 8 && cyc < 60) begin
            @(negedge clk);
            out_ready = !(cyc >= 5 && cyc < 8);
            in_valid  = (sent < 8);
            a = 16'(sent + 1); b = 16'(sent + 1); op = 2'b00; cin = 1'b0;
            #1;
            if (prev_stall) chk("stall.hold_r", r, prev_r);
            chk("stall.in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                chk("stall.result", r, 32'(2 * (got + 1)));
                got++;
            end
            if (out_valid && !out_ready) stalls++;
            prev_stall = out_valid && !out_ready;
            prev_r     = r;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        chk("stall.count", got, 8);
        chk("stall.cycles", stalls, 3);
        in_valid = 1'b0; out_ready = 1'b1;

        // Three ops in flight, first one held at the output, then asynchronous reset.
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; a = 16'(i); b = 16'(i); op = 2'b00; cin = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst.pre_valid", out_valid, 1);
        chk("rst.pre_r", r, 16'h0002);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.r", r, 0);
        chk("rst.flags", {cout, ovf, zero, neg}, 0);
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111;
        repeat (2) @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
        quiet = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        chk("rst.no_stale", quiet, 0);
        do_op("post_rst", 2'b00, 16'h0300, 16'h0045, 1'b0, 16'h0345, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
